// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, PC step, NOP encoding and fetch FSM states.
// Imported by if_fetch_unit and fetch_fifo.
package if_fetch_unit_pkg;

    localparam int                DWIDTH    = 32;
    localparam logic [DWIDTH-1:0] PC_STEP   = 32'd4;
    localparam logic [DWIDTH-1:0] INSTR_NOP = 32'h0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef struct packed {
        logic [DWIDTH-1:0] pc;
        logic [DWIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [DWIDTH-1:0] align_pc(input logic [DWIDTH-1:0] pc);
        return {pc[DWIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: synchronous prefetch FIFO holding {pc, instr} pairs.
// Flush has priority over push and pop; read data is the registered head entry.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 2 * DWIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch FSM, fetch PC, prefetch FIFO and ID handshake.
// Optional FETCH_BYPASS_EN forwards ack data straight to ID when the FIFO is empty.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DWIDTH-1:0] id_pc,
    output logic [DWIDTH-1:0] id_instr
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [1:0]          state_q, state_d;
    logic [DWIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DWIDTH-1:0]   drop_addr_q, drop_addr_d;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count, count_next;
    logic [2*DWIDTH-1:0] fifo_wdata, fifo_rdata;
    fetch_entry_t        head;
    logic                bypass_take;

    fetch_fifo #(
        .WIDTH (2 * DWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = (state_q == ST_REQ) & imem_ack & ~redirect_valid & fifo_empty;
    assign bypass_take = bypass & id_ready;
`else
    assign bypass_take = 1'b0;
`endif

    // The slot for an ack was reserved when its request issued, so fifo_full never blocks it.
    assign fifo_push  = (state_q == ST_REQ) & imem_ack & ~redirect_valid & ~bypass_take & ~fifo_full;
    assign fifo_pop   = ~fifo_empty & id_ready;
    assign fifo_flush = redirect_valid;
    assign fifo_wdata = {fetch_pc_q, imem_rdata};
    assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign head       = fetch_entry_t'(fifo_rdata);

    assign imem_req  = (state_q != ST_IDLE);
    assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

    always_comb begin
        id_valid = ~fifo_empty;
        id_pc    = fifo_empty ? '0 : head.pc;
        id_instr = fifo_empty ? INSTR_NOP : head.instr;
`ifdef FETCH_BYPASS_EN
        if (bypass) begin
            id_valid = 1'b1;
            id_pc    = fetch_pc_q;
            id_instr = imem_rdata;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            ST_IDLE: if (fifo_count < DEPTH_C) state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: if (imem_ack) state_d = (fifo_count < DEPTH_C) ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A redirect overrides everything; an un-acked request must still be retired in DROP.
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            case (state_q)
                ST_REQ: begin
                    state_d = imem_ack ? ST_REQ : ST_DROP;
                    if (!imem_ack) drop_addr_d = fetch_pc_q;
                end
                ST_DROP: state_d = imem_ack ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit (default and FETCH_BYPASS_EN builds).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    logic        zwMode;
    logic        ackMan;
    logic [31:0] rdataMan;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // Zero-wait imem answers every request immediately; otherwise the bench drives ack by hand.
    assign imem_ack   = zwMode ? imem_req : ackMan;
    assign imem_rdata = zwMode ? instr_of(imem_addr) : rdataMan;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .DWIDTH   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    task automatic apply_reset(input logic zw, input logic rdy);
        @(negedge clk);
        rst            = 1'b1;
        zwMode         = zw;
        ackMan         = 1'b0;
        rdataMan       = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", id_pc); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", id_instr); end
    endtask

    task automatic test_stream();
        int n;
        apply_reset(1'b1, 1'b1);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (id_valid === 1'b1) break;
        end
        checks++; if (n != FIRST_LAT) begin errors++; $display("[TB] FAIL stream_latency: got %0d expected %0d", n, FIRST_LAT); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_instr !== instr_of(32'(4 * k))) begin
                errors++;
                $display("[TB] FAIL stream_seq%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, id_valid, id_pc, id_instr, 32'(4 * k), instr_of(32'(4 * k)));
            end
        end
    endtask

    task automatic test_fill_drain();
        int          acks;
        logic        gotAddr;
        logic [31:0] firstAddr;
        apply_reset(1'b1, 1'b0);
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_ack === 1'b1) acks++;
        end
        checks++; if (acks != 4) begin errors++; $display("[TB] FAIL fill_acks: got %0d expected 4", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL fill_req_low: got %b expected 0", imem_req); end
        checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", dut.u_fifo.count); end
        id_ready  = 1'b1;
        gotAddr   = 1'b0;
        firstAddr = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (!gotAddr && imem_req === 1'b1) begin
                gotAddr   = 1'b1;
                firstAddr = imem_addr;
            end
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL drain_seq%0d: got v=%b pc=%h expected v=1 pc=%h", k, id_valid, id_pc, 32'(4 * k));
            end
        end
        checks++; if (firstAddr !== 32'h10) begin errors++; $display("[TB] FAIL drain_resume_addr: got %h expected 00000010", firstAddr); end
    endtask

    task automatic test_redirect_wait();
        apply_reset(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL drop_hold_addr: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
        end
        ackMan   = 1'b1;
        rdataMan = 32'hDEAD_BEEF;
        @(negedge clk);
        ackMan = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_discard: got %b expected 0", id_valid); end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL drop_next_addr: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr);
        end
        ackMan   = 1'b1;
        rdataMan = instr_of(32'h100);
        @(negedge clk);
        ackMan = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== instr_of(32'h100)) begin
            errors++; $display("[TB] FAIL drop_first_id: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=%h",
                               id_valid, id_pc, id_instr, instr_of(32'h100));
        end
    endtask

    task automatic test_redirect_ack();
        int n;
        apply_reset(1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 10);
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL redir_ack_reach8: got %0d cycles expected 3", n); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL redir_ack_addr: got %h expected 00000040", imem_addr); end
        checks++;
        if (id_valid === 1'b1 && id_pc === 32'h8) begin
            errors++; $display("[TB] FAIL redir_ack_leak: got pc=%h expected not 00000008", id_pc);
        end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin errors++; $display("[TB] FAIL redir_ack_first: got v=%b pc=%h expected v=1 pc=00000040", id_valid, id_pc); end
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (id_pc !== 32'h44) begin errors++; $display("[TB] FAIL redir_ack_second: got %h expected 00000044", id_pc); end
        @(negedge clk);
        checks++; if (id_pc !== 32'h48) begin errors++; $display("[TB] FAIL redir_ack_third: got %h expected 00000048", id_pc); end
    endtask

    task automatic test_wrap();
        apply_reset(1'b1, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_aligned: got %h expected fffffffc", imem_addr); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_to_zero: got %h expected 00000000", imem_addr); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_id_pc: got v=%b pc=%h expected v=1 pc=fffffffc", id_valid, id_pc); end
    endtask

    task automatic test_reset_midflight();
        apply_reset(1'b0, 1'b1);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending: got %b expected 1", imem_req); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outs: got req=%b v=%b expected 0 0", imem_req, id_valid); end
        rst      = 1'b0;
        ackMan   = 1'b1;
        rdataMan = 32'hBAD0_0BAD;
        @(negedge clk);
        ackMan = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_late_ack: got %b expected 0", id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
